// File: rtl/sccb_reg_sequencer_if.sv
// Bundles the register request/response port and the three I2C master streams.
// master = the sequencer's view, slave = the driver / I2C master peer view.
interface sccb_reg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_read;
  logic [7:0] req_reg;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [6:0] s_axis_cmd_address;
  logic       s_axis_cmd_start;
  logic       s_axis_cmd_read;
  logic       s_axis_cmd_write;
  logic       s_axis_cmd_write_multiple;
  logic       s_axis_cmd_stop;
  logic       s_axis_cmd_valid;
  logic       s_axis_cmd_ready;
  logic [7:0] s_axis_data_tdata;
  logic       s_axis_data_tvalid;
  logic       s_axis_data_tlast;
  logic       s_axis_data_tready;
  logic [7:0] m_axis_data_tdata;
  logic       m_axis_data_tvalid;
  logic       m_axis_data_tlast;
  logic       m_axis_data_tready;

  modport master (
    input  req_valid, req_read, req_reg, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy,
    output s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write,
    output s_axis_cmd_write_multiple, s_axis_cmd_stop, s_axis_cmd_valid,
    input  s_axis_cmd_ready,
    output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    input  s_axis_data_tready,
    input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
    output m_axis_data_tready
  );

  modport slave (
    output req_valid, req_read, req_reg, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
    input  s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write,
    input  s_axis_cmd_write_multiple, s_axis_cmd_stop, s_axis_cmd_valid,
    output s_axis_cmd_ready,
    input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    output s_axis_data_tready,
    output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
    input  m_axis_data_tready
  );
endinterface

// File: rtl/sccb_reg_sequencer.sv
// Turns one OV7670 register write/read request into I2C master command/data stream traffic.
// Register reads are built only when SCCB_READ_EN is defined; otherwise reads are rejected with rsp_err.
module sccb_reg_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h21,
  parameter logic [15:0] RD_TIMEOUT = 16'd50000
) (
  input  logic                        clk,
  input  logic                        reset_,
  sccb_reg_sequencer_if.master        bus
);

`ifdef SCCB_READ_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, W_CMD = 3'd1, W_REG = 3'd2, W_VAL = 3'd3,
    R_CMD = 3'd4, R_DATA = 3'd5, DONE = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, W_CMD = 3'd1, W_REG = 3'd2, W_VAL = 3'd3, DONE = 3'd6
  } state_t;
`endif

  state_t     state_q, state_d;
  logic       rd_q, rd_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rdy_q;
  logic       accept_s;
`ifdef SCCB_READ_EN
  logic [15:0] cnt_q, cnt_d;
  logic        unused_s;
  assign unused_s = bus.m_axis_data_tlast;
`else
  logic        unused_s;
  assign unused_s = ^{bus.m_axis_data_tlast, bus.m_axis_data_tvalid,
                      bus.m_axis_data_tdata, RD_TIMEOUT};
`endif

  // rdy_q holds req_ready low until the first edge that samples reset_ released
  assign accept_s = bus.req_valid && (state_q == IDLE) && rdy_q;

  // Next-state and latched-field logic
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    reg_d      = reg_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef SCCB_READ_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          rd_d       = bus.req_read;
          reg_d      = bus.req_reg;
          data_d     = bus.req_data;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b0;
`ifdef SCCB_READ_EN
          state_d    = W_CMD;
`else
          if (bus.req_read) begin
            state_d   = DONE;
            rsp_err_d = 1'b1;
          end else begin
            state_d   = W_CMD;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      W_CMD: begin
        if (bus.s_axis_cmd_ready) state_d = W_REG;
        else                      state_d = W_CMD;
      end
      W_REG: begin
        if (bus.s_axis_data_tready) begin
`ifdef SCCB_READ_EN
          state_d = rd_q ? R_CMD : W_VAL;
`else
          state_d = W_VAL;
`endif
        end else begin
          state_d = W_REG;
        end
      end
      W_VAL: begin
        if (bus.s_axis_data_tready) state_d = DONE;
        else                        state_d = W_VAL;
      end
`ifdef SCCB_READ_EN
      R_CMD: begin
        if (bus.s_axis_cmd_ready) begin
          state_d = R_DATA;
          cnt_d   = 16'd0;
        end else begin
          state_d = R_CMD;
        end
      end
      R_DATA: begin
        if (bus.m_axis_data_tvalid) begin
          state_d    = DONE;
          rsp_data_d = bus.m_axis_data_tdata;
          rsp_err_d  = 1'b0;
        end else if (cnt_q == (RD_TIMEOUT - 16'd1)) begin
          state_d    = DONE;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and field registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      rd_q       <= 1'b0;
      reg_q      <= 8'h00;
      data_q     <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
`ifdef SCCB_READ_EN
      cnt_q      <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef SCCB_READ_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE) && rdy_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_err   = (state_q == DONE) && rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

  // Payload comes only from flops that change in IDLE, so it is stable under backpressure
`ifdef SCCB_READ_EN
  assign bus.s_axis_cmd_valid   = (state_q == W_CMD) || (state_q == R_CMD);
  assign bus.s_axis_cmd_read    = (state_q == R_CMD);
  assign bus.m_axis_data_tready = (state_q == R_DATA);
`else
  assign bus.s_axis_cmd_valid   = (state_q == W_CMD);
  assign bus.s_axis_cmd_read    = 1'b0;
  assign bus.m_axis_data_tready = 1'b0;
`endif
  assign bus.s_axis_cmd_address        = DEV_ADDR;
  assign bus.s_axis_cmd_start          = bus.s_axis_cmd_valid;
  assign bus.s_axis_cmd_stop           = bus.s_axis_cmd_valid;
  assign bus.s_axis_cmd_write          = 1'b0;
  assign bus.s_axis_cmd_write_multiple = (state_q == W_CMD);

  assign bus.s_axis_data_tvalid = (state_q == W_REG) || (state_q == W_VAL);
  assign bus.s_axis_data_tdata  = (state_q == W_REG) ? reg_q :
                                  (state_q == W_VAL) ? data_q : 8'h00;
  assign bus.s_axis_data_tlast  = (state_q == W_REG) ? rd_q : (state_q == W_VAL);

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Scoreboard bench for sccb_reg_sequencer: expected commands, bytes and responses are queued
// when a request is driven and popped as the DUT produces them.
module tb_sccb_reg_sequencer;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  sccb_reg_sequencer_if bus ();

  sccb_reg_sequencer #(.DEV_ADDR(7'h21), .RD_TIMEOUT(16'd10)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.master)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         at;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [11:0] cmd_q[$];   // {addr, start, read, write, write_multiple, stop}
  logic [8:0]  wr_q[$];    // {tdata, tlast}

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int cmd_stall = 0, wr_stall = 0, rd_delay = 0;
  int cmd_wait = 0, wr_wait = 0, rd_wait = 0;
  bit rd_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  bit cmd_hold = 1'b0, wr_hold = 1'b0;
  logic [12:0] cmd_prev;
  logic [9:0]  wr_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Peer readies/read data are set at the negedge, then handshakes due at the next posedge are scored
  always @(negedge clk) begin
    logic [11:0] cmd_now;
    logic [8:0]  wr_now;
    rsp_t        e;
    if (bus.s_axis_cmd_valid) begin
      if (cmd_wait < cmd_stall) begin bus.s_axis_cmd_ready = 1'b0; cmd_wait++; end
      else begin bus.s_axis_cmd_ready = 1'b1; cmd_wait = 0; end
    end else bus.s_axis_cmd_ready = 1'b0;
    if (bus.s_axis_data_tvalid) begin
      if (wr_wait < wr_stall) begin bus.s_axis_data_tready = 1'b0; wr_wait++; end
      else begin bus.s_axis_data_tready = 1'b1; wr_wait = 0; end
    end else bus.s_axis_data_tready = 1'b0;
    if (bus.m_axis_data_tready && rd_en) begin
      if (rd_wait < rd_delay) begin bus.m_axis_data_tvalid = 1'b0; rd_wait++; end
      else begin bus.m_axis_data_tvalid = 1'b1; bus.m_axis_data_tdata = rd_byte; rd_wait = 0; end
    end else bus.m_axis_data_tvalid = 1'b0;

    if (reset_) begin
      cmd_now = {bus.s_axis_cmd_address, bus.s_axis_cmd_start, bus.s_axis_cmd_read,
                 bus.s_axis_cmd_write, bus.s_axis_cmd_write_multiple, bus.s_axis_cmd_stop};
      wr_now  = {bus.s_axis_data_tdata, bus.s_axis_data_tlast};
      if (cmd_hold) check_eq("cmd_stable", {bus.s_axis_cmd_valid, cmd_now}, cmd_prev);
      if (wr_hold)  check_eq("data_stable", {bus.s_axis_data_tvalid, wr_now}, wr_prev);
      cmd_hold = bus.s_axis_cmd_valid && !bus.s_axis_cmd_ready;
      cmd_prev = {bus.s_axis_cmd_valid, cmd_now};
      wr_hold  = bus.s_axis_data_tvalid && !bus.s_axis_data_tready;
      wr_prev  = {bus.s_axis_data_tvalid, wr_now};
      if (bus.s_axis_cmd_valid && bus.s_axis_cmd_ready) begin
        if (cmd_q.size() == 0) check_eq("cmd_unexpected", 32'd1, 32'd0);
        else check_eq("cmd", cmd_now, cmd_q.pop_front());
      end
      if (bus.s_axis_data_tvalid && bus.s_axis_data_tready) begin
        if (wr_q.size() == 0) check_eq("data_unexpected", 32'd1, 32'd0);
        else check_eq("data", wr_now, wr_q.pop_front());
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) check_eq("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = rsp_q.pop_front();
          check_eq("rsp_data", bus.rsp_data, e.data);
          check_eq("rsp_err", bus.rsp_err, e.err);
          check_eq("rsp_cycle", cyc, e.at);
        end
      end
    end else begin
      cmd_hold = 1'b0;
      wr_hold  = 1'b0;
    end
  end

  // lat = cycle of rsp_valid counted from the accept edge (edge 0)
  task automatic issue(input bit rd, input logic [7:0] r, input logic [7:0] d,
                       input int lat, input logic [7:0] rdata, input bit err);
    rsp_t e;
    @(negedge clk); #1;
    bus.req_read = rd; bus.req_reg = r; bus.req_data = d; bus.req_valid = 1'b1;
    for (int n = 0; n < 200 && !bus.req_ready; n++) begin @(negedge clk); #1; end
    if (!bus.req_ready) begin
      check_eq("req_ready_wait", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (!rd) begin
      cmd_q.push_back({7'h21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
      wr_q.push_back({r, 1'b0});
      wr_q.push_back({d, 1'b1});
    end else begin
`ifdef SCCB_READ_EN
      cmd_q.push_back({7'h21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
      wr_q.push_back({r, 1'b1});
      cmd_q.push_back({7'h21, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
`endif
    end
    e.data = rdata; e.err = err; e.at = cyc + lat;
    rsp_q.push_back(e);
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 300 && rsp_q.size() != 0; n++) begin @(negedge clk); #1; end
    if (rsp_q.size() != 0) begin
      check_eq(tag, rsp_q.size(), 32'd0);
      rsp_q.delete(); cmd_q.delete(); wr_q.delete();
    end
    @(negedge clk); #1;
    check_eq("ready_back", bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_reg = 8'h00; bus.req_data = 8'h00;
    bus.s_axis_cmd_ready = 1'b0; bus.s_axis_data_tready = 1'b0;
    bus.m_axis_data_tvalid = 1'b0; bus.m_axis_data_tdata = 8'h00; bus.m_axis_data_tlast = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_ready", bus.req_ready, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 10'h000);
    check_eq("rst_valids", {bus.s_axis_cmd_valid, bus.s_axis_data_tvalid, bus.m_axis_data_tready}, 3'b000);
    check_eq("rst_addr", bus.s_axis_cmd_address, 7'h21);
    check_eq("rst_payload", {bus.s_axis_data_tdata, bus.s_axis_data_tlast, bus.s_axis_cmd_start,
                             bus.s_axis_cmd_write_multiple, bus.s_axis_cmd_stop}, 12'h000);
    reset_ = 1'b1;
    @(negedge clk); #1;
    check_eq("ready_after_release", bus.req_ready, 1'b1);

    issue(1'b0, 8'h12, 8'h80, 4, 8'h00, 1'b0);
    wait_done("wr_basic_timeout");
    cmd_stall = 5; wr_stall = 3;
    issue(1'b0, 8'h12, 8'h80, 15, 8'h00, 1'b0);
    wait_done("wr_stall_timeout");
    cmd_stall = 0; wr_stall = 0;
    issue(1'b0, 8'h3A, 8'hC5, 4, 8'h00, 1'b0);
    wait_done("wr2_timeout");

`ifdef SCCB_READ_EN
    rd_en = 1'b1; rd_byte = 8'h76; rd_delay = 0;
    issue(1'b1, 8'h0A, 8'hEE, 5, 8'h76, 1'b0);
    wait_done("rd_timeout");
    rd_byte = 8'h3C; rd_delay = 2;
    issue(1'b1, 8'h55, 8'h00, 7, 8'h3C, 1'b0);
    wait_done("rd_delay_timeout");
    issue(1'b0, 8'h11, 8'h01, 4, 8'h00, 1'b0);
    wait_done("wr_after_rd_timeout");
    rd_en = 1'b0;
    issue(1'b1, 8'h0B, 8'h00, 14, 8'h00, 1'b1);
    wait_done("rd_abort_timeout");
`else
    issue(1'b1, 8'h0A, 8'h99, 1, 8'h00, 1'b1);
    wait_done("rd_reject_timeout");
    issue(1'b0, 8'h11, 8'h01, 4, 8'h00, 1'b0);
    wait_done("wr_after_reject_timeout");
`endif

    // Reset while the value byte is stalled: no response may follow
    wr_stall = 50;
    issue(1'b0, 8'h40, 8'hA5, 100, 8'h00, 1'b0);
    for (int n = 0; n < 200 && !(bus.s_axis_data_tvalid && bus.s_axis_data_tlast); n++) begin
      @(negedge clk); #1;
    end
    check_eq("reached_w_val", bus.s_axis_data_tvalid && bus.s_axis_data_tlast, 1'b1);
    reset_ = 1'b0;
    @(negedge clk); #1;
    check_eq("mid_rst_valids", {bus.s_axis_cmd_valid, bus.s_axis_data_tvalid, bus.m_axis_data_tready}, 3'b000);
    check_eq("mid_rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 10'h000);
    check_eq("mid_rst_ready_busy", {bus.req_ready, bus.busy}, 2'b00);
    rsp_q.delete(); cmd_q.delete(); wr_q.delete();
    wr_stall = 0; wr_wait = 0;
    reset_ = 1'b1;
    @(negedge clk); #1;
    check_eq("ready_after_mid_rst", bus.req_ready, 1'b1);
    repeat (6) @(negedge clk);
    #1;
    issue(1'b0, 8'h6B, 8'h0F, 4, 8'h00, 1'b0);
    wait_done("wr_recover_timeout");

    repeat (5) @(negedge clk);
    #1;
    check_eq("sb_empty", cmd_q.size() + wr_q.size() + rsp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
